// File: rtl/top_level.sv
// Purpose: transmit path with an 8-entry replay buffer; NAK or timer expiry replays every unacknowledged word, starting with the oldest.
// Latency: an accepted write appears on dout 1 cycle later; a replay emits one buffered word per free-link cycle.
// Backpressure: busy_n=0 stalls writes and freezes replay; a full buffer or an active replay drops ready.
module top_level #(
    parameter int          DEPTH    = 8,
    parameter logic [11:0] SEQ_INIT = 12'h001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        busy_n,
    input  logic        tim_out,
    input  logic        we,
    input  logic [1:0]  ack_nak,
    input  logic [15:0] din,
    input  logic [11:0] seq,
    output logic        ready,
    output logic [15:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [11:0] seq;
        logic [15:0] dat;
    } entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    entry_t        mem [DEPTH];

    state_t        state,   state_nxt;
    logic [AW-1:0] wr_ptr,  wr_ptr_nxt;
    logic [AW-1:0] old_ptr, old_ptr_nxt;
    logic [AW-1:0] rp_ptr,  rp_ptr_nxt;
    logic [AW-1:0] rp_cur;
    logic [CW-1:0] count,   count_nxt;
    logic [11:0]   exp_seq, exp_seq_nxt;
    logic [15:0]   dout_nxt;

    logic          wr_acc;
    logic          ack_vld;
    logic          nak_vld;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // New words are taken only when there is room, no replay is running and the link is free.
    assign ready   = reset_n && (count < CW'(DEPTH)) && (state == ST_IDLE) && busy_n;
    assign wr_acc  = we && ready && (seq == exp_seq);
    assign ack_vld = (ack_nak == 2'b01) && (count != '0);
    assign nak_vld = ((ack_nak == 2'b10) || tim_out) && (count != '0);

    // Next-state: write/ACK bookkeeping first, then the replay engine works on the post-ACK buffer.
    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        old_ptr_nxt = old_ptr;
        rp_ptr_nxt  = rp_ptr;
        rp_cur      = rp_ptr;
        count_nxt   = count;
        exp_seq_nxt = exp_seq;
        dout_nxt    = dout;

        if (wr_acc) begin
            wr_ptr_nxt  = ptr_inc(wr_ptr);
            exp_seq_nxt = exp_seq + 12'd1;
            dout_nxt    = din;
        end

        // A freed entry that the replay was about to send is skipped.
        if (ack_vld) begin
            old_ptr_nxt = ptr_inc(old_ptr);
            if (rp_ptr == old_ptr) begin
                rp_cur = ptr_inc(old_ptr);
            end
        end

        case ({wr_acc, ack_vld})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        case (state)
            ST_REPLAY: begin
                if (count_nxt == '0) begin
                    state_nxt = ST_IDLE;
                end else if (nak_vld) begin
                    // Restart from the oldest surviving entry; nothing is sent this cycle.
                    rp_ptr_nxt = old_ptr_nxt;
                end else if (busy_n) begin
                    dout_nxt   = mem[rp_cur].dat;
                    rp_ptr_nxt = ptr_inc(rp_cur);
                    if (ptr_inc(rp_cur) == wr_ptr) begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    rp_ptr_nxt = rp_cur;
                end
            end
            default: begin
                if (nak_vld && (count_nxt != '0)) begin
                    state_nxt  = ST_REPLAY;
                    rp_ptr_nxt = old_ptr_nxt;
                end
            end
        endcase
    end

    // Control and output registers; reset empties the buffer logically.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            old_ptr <= '0;
            rp_ptr  <= '0;
            count   <= '0;
            exp_seq <= SEQ_INIT;
            dout    <= 16'h0000;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            old_ptr <= old_ptr_nxt;
            rp_ptr  <= rp_ptr_nxt;
            count   <= count_nxt;
            exp_seq <= exp_seq_nxt;
            dout    <= dout_nxt;
        end
    end

    // Replay storage; stale contents after reset are harmless because count is zero.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= entry_t'{seq: seq, dat: din};
        end
    end

    // Entries are stored in sequence order, so the oldest seq always trails expected-seq by the occupancy.
    always_ff @(posedge clk) begin
        if (reset_n && (count != '0)) begin
            assert (mem[old_ptr].seq == (exp_seq - 12'(count)));
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Randomized and directed stimulus against a queue-based reference of the replay buffer.
// Expected ready/dout per cycle go into a scoreboard queue; a monitor pops and compares after each edge.
// All waits are bounded by fixed cycle counts and a global watchdog.
module tb_top_level;

    logic        clk;
    logic        reset_n;
    logic        busy_n;
    logic        tim_out;
    logic        we;
    logic [1:0]  ack_nak;
    logic [15:0] din;
    logic [11:0] seq;
    logic        ready;
    logic [15:0] dout;

    top_level #(.DEPTH(8), .SEQ_INIT(12'h001)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .busy_n  (busy_n),
        .tim_out (tim_out),
        .we      (we),
        .ack_nak (ack_nak),
        .din     (din),
        .seq     (seq),
        .ready   (ready),
        .dout    (dout)
    );

    typedef struct {
        logic        rdy;
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;

    // Reference: unacknowledged payloads in order, plus a replay cursor as an offset from the oldest.
    logic [15:0] mq[$];
    logic [11:0] m_exp;
    logic        m_replay;
    int          m_off;
    logic [15:0] m_dout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        mq.delete();
        m_exp    = 12'h001;
        m_replay = 1'b0;
        m_off    = 0;
        m_dout   = 16'h0000;
    endtask

    task automatic model_step(input logic r, input logic b, input logic t, input logic w,
                              input logic [1:0] an, input logic [15:0] d, input logic [11:0] s);
        logic acc, ack, nak, was_rp;
        if (!r) begin
            model_reset();
            return;
        end
        acc    = w && (mq.size() < 8) && !m_replay && b && (s == m_exp);
        ack    = (an == 2'b01) && (mq.size() > 0);
        nak    = ((an == 2'b10) || t) && (mq.size() > 0);
        was_rp = m_replay;
        if (ack) begin
            void'(mq.pop_front());
            if (m_off > 0) m_off--;
        end
        if (acc) begin
            mq.push_back(d);
            m_exp  = m_exp + 12'd1;
            m_dout = d;
        end
        if (was_rp) begin
            if (mq.size() == 0) begin
                m_replay = 1'b0;
            end else if (nak) begin
                m_off = 0;
            end else if (b) begin
                m_dout = mq[m_off];
                m_off++;
                if (m_off == mq.size()) m_replay = 1'b0;
            end
        end else if (nak && (mq.size() > 0)) begin
            m_replay = 1'b1;
            m_off    = 0;
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic t, input logic w,
                         input logic [1:0] an, input logic [15:0] d, input logic [11:0] s);
        exp_t e;
        @(negedge clk);
        reset_n = r;
        busy_n  = b;
        tim_out = t;
        we      = w;
        ack_nak = an;
        din     = d;
        seq     = s;
        model_step(r, b, t, w, an, d, s);
        e.rdy = r && (mq.size() < 8) && !m_replay && b;
        e.dat = m_dout;
        e.cyc = cyc_cnt;
        sb.push_back(e);
        cyc_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 12'h000);
    endtask

    task automatic wr(input logic [15:0] d);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, d, m_exp);
    endtask

    // Monitor: compare DUT outputs just after every rising edge against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL ready cyc=%0d got=%b exp=%b", e.cyc, ready, e.rdy);
                end
                n_checks++;
                if (dout !== e.dat) begin
                    n_fail++;
                    $display("FAIL dout cyc=%0d got=%h exp=%h", e.cyc, dout, e.dat);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog timeout cyc=%0d got=running exp=finished", cyc_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int guard;
        reset_n = 1'b0;
        busy_n  = 1'b1;
        tim_out = 1'b0;
        we      = 1'b0;
        ack_nak = 2'b00;
        din     = 16'h0000;
        seq     = 12'h000;
        model_reset();

        // Reset held with an otherwise valid write presented.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0001, 12'h001);

        // First edge after release accepts; out-of-order seq is dropped.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'hAAAA, 12'h001);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'hBBBB, 12'h002);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'hCCCC, 12'h005);
        idle(1);

        // Fill to eight, ninth dropped, one ACK reopens.
        for (int i = 0; i < 6; i++) wr(16'h1000 + 16'(i));
        wr(16'h9999);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0000, 12'h000);
        idle(1);

        // Replay by NAK, by timer, and with a two-cycle link stall in the middle.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 12'h000);
        wr(16'hA0A0);
        wr(16'hB0B0);
        wr(16'hC0C0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 16'h0000, 12'h000);
        idle(5);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        idle(5);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 16'h0000, 12'h000);
        idle(1);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 12'h000);
        idle(4);

        // ACK plus write at count 3, drain, then NAK on an empty buffer.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'hD0D0, m_exp);
        idle(1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0000, 12'h000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 16'h0000, 12'h000);
        idle(2);

        // Walk expected-seq up to FFF with write+ACK each cycle, then check the wrap.
        guard = 0;
        while ((m_exp != 12'hFFF) && (guard < 5000)) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'($urandom), m_exp);
            guard++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'hF00F, 12'hFFF);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h1111, 12'h001);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0F0F, 12'h000);
        idle(2);

        // Random traffic with occasional resets, stalls, NAKs and timer expiries.
        for (int i = 0; i < 4000; i++) begin
            logic        r, b, t, w;
            logic [1:0]  an;
            logic [11:0] s;
            int          k;
            r = ($urandom_range(0, 199) != 0);
            b = ($urandom_range(0, 9) < 8);
            t = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 1) == 1);
            k = $urandom_range(0, 19);
            an = (k < 6) ? 2'b01 : (k == 6) ? 2'b10 : (k == 7) ? 2'b11 : 2'b00;
            s = ($urandom_range(0, 9) < 8) ? m_exp : 12'($urandom);
            drive(r, b, t, w, an, 16'($urandom), s);
        end
        idle(3);

        guard = 0;
        while ((sb.size() != 0) && (guard < 20)) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
